// File: rtl/billiard_pkg.sv
// Shared types for the cue aiming / shot path of the billiard game.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package billiard_pkg;

    // Signed screen coordinate / offset / velocity, 11 bits.
    typedef logic signed [10:0] coord_t;

    typedef enum logic [1:0] {
        WAIT_STILL = 2'd0,
        AIM        = 2'd1,
        FIRE       = 2'd2,
        COOLDOWN   = 2'd3
    } aim_state_t;

    // Top-left to ball-centre distance in pixels, both axes.
    localparam int BALL_OFFSET_DEFAULT = 16;

endpackage

// File: rtl/aim_key_step.sv
// One axis of the aim offset: applies a +/-STEP move from a key pair and saturates to +/-MAX.
// Latency: combinational.
// Backpressure: none; the result is only meaningful when step_en is high, otherwise cur passes through.
// Ports: dec/inc keys (level), step_en (apply this cycle), cur (present offset), nxt (offset to register).
module aim_key_step
    import billiard_pkg::*;
#(
    parameter int STEP = 2,
    parameter int MAX  = 128
) (
    input  logic   dec,
    input  logic   inc,
    input  logic   step_en,
    input  coord_t cur,
    output coord_t nxt
);

    // One guard bit so cur +/- STEP cannot wrap before the clamp sees it.
    localparam logic signed [11:0] MAX_POS = 12'(MAX);
    localparam logic signed [11:0] MAX_NEG = -12'(MAX);
    localparam logic signed [11:0] STEP_W  = 12'(STEP);

    logic signed [11:0] delta;
    logic signed [11:0] sum;

    always_comb begin
        delta = '0;
        // Both keys held cancel out.
        if (inc && !dec) begin
            delta = STEP_W;
        end else if (dec && !inc) begin
            delta = -STEP_W;
        end
        sum = {cur[10], cur} + delta;

        nxt = cur;
        if (step_en) begin
            if (sum > MAX_POS) begin
                nxt = MAX_POS[10:0];
            end else if (sum < MAX_NEG) begin
                nxt = MAX_NEG[10:0];
            end else begin
                nxt = sum[10:0];
            end
        end
    end

endmodule

// File: rtl/cue_aim_controller.sv
// Owns the aim vector drawn from the cue-ball centre, steps it from arrow keys each frame, fires a shot on Enter.
// Latency: aimPos/drawLineEnable registered 1 cycle after inputs; shotValid 1 cycle after the Enter rising edge.
// Backpressure: none; shotValid is a single-cycle pulse the physics block must take when it appears.
// Ports: clk, reset (sync, active-high), startOfFrame, ballPosX/Y, ballsStill, arrow keys, keyEnterIsPressed
//        -> aimPosX/Y, drawLineEnable, shotValid, shotSpeedX/Y.
module cue_aim_controller
    import billiard_pkg::*;
#(
    parameter int BALL_OFFSET     = BALL_OFFSET_DEFAULT,
    parameter int AIM_MAX         = 128,
    parameter int AIM_STEP        = 2,
    parameter int AIM_RESET_DX    = 64,
    parameter int SPEED_SHIFT     = 2,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   startOfFrame,
    input  coord_t ballPosX,
    input  coord_t ballPosY,
    input  logic   ballsStill,
    input  logic   keyLeft,
    input  logic   keyRight,
    input  logic   keyUp,
    input  logic   keyDown,
    input  logic   keyEnterIsPressed,
    output coord_t aimPosX,
    output coord_t aimPosY,
    output logic   drawLineEnable,
    output logic   shotValid,
    output coord_t shotSpeedX,
    output coord_t shotSpeedY
);

    localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

    aim_state_t       state;
    aim_state_t       state_nxt;
    coord_t           dx;
    coord_t           dy;
    coord_t           dx_nxt;
    coord_t           dy_nxt;
    logic             enter_prev;
    logic [CNT_W-1:0] cd_cnt;
    logic             enter_rise;
    logic             fire;
    logic             step_en;
    logic             cd_done;

    always_comb begin
        enter_rise = keyEnterIsPressed && !enter_prev;
        // A zero vector has no direction, so an Enter edge on it is ignored.
        fire       = (state == AIM) && enter_rise && ballsStill && ((dx != '0) || (dy != '0));
        // A shot launched on a frame tick uses the vector as displayed; the tick is dropped.
        step_en    = (state == AIM) && startOfFrame && !fire;
        cd_done    = (cd_cnt == CNT_W'(COOLDOWN_FRAMES));

        state_nxt = state;
        case (state)
            WAIT_STILL: if (ballsStill) state_nxt = AIM;
            AIM: begin
                if (!ballsStill) begin
                    state_nxt = WAIT_STILL;
                end else if (fire) begin
                    state_nxt = FIRE;
                end
            end
            FIRE:       state_nxt = COOLDOWN;
            // Enter still held after the cooldown keeps us here so one long press cannot fire twice.
            COOLDOWN:   if (cd_done && !keyEnterIsPressed) state_nxt = WAIT_STILL;
            default:    state_nxt = WAIT_STILL;
        endcase
    end

    aim_key_step #(.STEP(AIM_STEP), .MAX(AIM_MAX)) u_step_x (
        .dec     (keyLeft),
        .inc     (keyRight),
        .step_en (step_en),
        .cur     (dx),
        .nxt     (dx_nxt)
    );

    aim_key_step #(.STEP(AIM_STEP), .MAX(AIM_MAX)) u_step_y (
        .dec     (keyUp),
        .inc     (keyDown),
        .step_en (step_en),
        .cur     (dy),
        .nxt     (dy_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_STILL;
            dx             <= coord_t'(AIM_RESET_DX);
            dy             <= '0;
            // Treat Enter as already held so a press spanning reset never fires.
            enter_prev     <= 1'b1;
            cd_cnt         <= '0;
            aimPosX        <= '0;
            aimPosY        <= '0;
            drawLineEnable <= 1'b0;
            shotValid      <= 1'b0;
            shotSpeedX     <= '0;
            shotSpeedY     <= '0;
        end else begin
            state          <= state_nxt;
            dx             <= dx_nxt;
            dy             <= dy_nxt;
            enter_prev     <= keyEnterIsPressed;
            // No screen clamping here; the line drawer clips.
            aimPosX        <= ballPosX + coord_t'(BALL_OFFSET) + dx;
            aimPosY        <= ballPosY + coord_t'(BALL_OFFSET) + dy;
            drawLineEnable <= (state == AIM);
            shotValid      <= fire;
            if (fire) begin
                shotSpeedX <= dx <<< SPEED_SHIFT;
                shotSpeedY <= dy <<< SPEED_SHIFT;
            end
            if (state == FIRE) begin
                cd_cnt <= '0;
            end else if ((state == COOLDOWN) && startOfFrame && !cd_done) begin
                cd_cnt <= cd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cue_aim_controller.sv
// Bench for cue_aim_controller: directed scenarios then random keys, checked against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cue_aim_controller;

    logic               clk = 1'b0;
    logic               reset;
    logic               startOfFrame;
    logic signed [10:0] ballPosX, ballPosY;
    logic               ballsStill;
    logic               keyLeft, keyRight, keyUp, keyDown, keyEnterIsPressed;
    logic signed [10:0] aimPosX, aimPosY, shotSpeedX, shotSpeedY;
    logic               drawLineEnable, shotValid;

    always #5 clk = ~clk;

    cue_aim_controller dut (
        .clk               (clk),
        .reset             (reset),
        .startOfFrame      (startOfFrame),
        .ballPosX          (ballPosX),
        .ballPosY          (ballPosY),
        .ballsStill        (ballsStill),
        .keyLeft           (keyLeft),
        .keyRight          (keyRight),
        .keyUp             (keyUp),
        .keyDown           (keyDown),
        .keyEnterIsPressed (keyEnterIsPressed),
        .aimPosX           (aimPosX),
        .aimPosY           (aimPosY),
        .drawLineEnable    (drawLineEnable),
        .shotValid         (shotValid),
        .shotSpeedX        (shotSpeedX),
        .shotSpeedY        (shotSpeedY)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_shots  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int ax; int ay; int dle; int sv; } exp_t;
    typedef struct { int sx; int sy; } shot_t;
    exp_t  expq[$];
    shot_t shotq[$];

    // phase: 0 waiting for balls to stop, 1 aiming, 2 firing, 3 cooling down
    int m_phase, m_dx, m_dy, m_frames, m_ax, m_ay, m_dle, m_sv;
    bit m_enter_prev;

    function automatic int wrap11(input int v);
        logic signed [10:0] t;
        t = v[10:0];
        return int'(t);
    endfunction

    function automatic int clamp128(input int v);
        if (v > 128) return 128;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_step();
        bit rise, shoot;
        int ph;
        if (reset) begin
            m_phase = 0; m_dx = 64; m_dy = 0; m_enter_prev = 1'b1; m_frames = 0;
            m_ax = 0; m_ay = 0; m_dle = 0; m_sv = 0;
        end else begin
            rise  = keyEnterIsPressed && !m_enter_prev;
            shoot = (m_phase == 1) && rise && ballsStill && (m_dx != 0 || m_dy != 0);
            m_ax  = wrap11(int'(ballPosX) + 16 + m_dx);
            m_ay  = wrap11(int'(ballPosY) + 16 + m_dy);
            m_dle = (m_phase == 1) ? 1 : 0;
            m_sv  = shoot ? 1 : 0;
            if (shoot) shotq.push_back('{m_dx * 4, m_dy * 4});
            if (m_phase == 1 && startOfFrame && !shoot) begin
                m_dx = clamp128(m_dx + 2 * (int'(keyRight) - int'(keyLeft)));
                m_dy = clamp128(m_dy + 2 * (int'(keyDown) - int'(keyUp)));
            end
            ph = m_phase;
            case (ph)
                0: if (ballsStill) m_phase = 1;
                1: if (!ballsStill) m_phase = 0; else if (shoot) m_phase = 2;
                2: begin m_phase = 3; m_frames = 0; end
                default: begin
                    if (m_frames >= 4 && !keyEnterIsPressed) m_phase = 0;
                    else if (startOfFrame && m_frames < 4) m_frames++;
                end
            endcase
            m_enter_prev = keyEnterIsPressed;
        end
        expq.push_back('{m_ax, m_ay, m_dle, m_sv});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor ----------------
    initial forever begin
        exp_t  e;
        shot_t s;
        @(negedge clk);
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("aimPosX", int'(aimPosX), e.ax);
            chk("aimPosY", int'(aimPosY), e.ay);
            chk("drawLineEnable", int'(drawLineEnable), e.dle);
            chk("shotValid", int'(shotValid), e.sv);
        end
        if (shotValid === 1'b1) begin
            n_shots++;
            if (shotq.size() > 0) begin
                s = shotq.pop_front();
                chk("shotSpeedX", int'(shotSpeedX), s.sx);
                chk("shotSpeedY", int'(shotSpeedY), s.sy);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: a startOfFrame pulse followed by three quiet cycles.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1; step(1);
            startOfFrame = 1'b0; step(3);
        end
    endtask

    task automatic keys(input bit l, input bit r, input bit u, input bit d);
        keyLeft = l; keyRight = r; keyUp = u; keyDown = d;
    endtask

    initial begin
        int shots_before;
        reset = 1'b1; startOfFrame = 1'b0; ballPosX = 11'sd0; ballPosY = 11'sd0;
        ballsStill = 1'b1; keys(0, 0, 0, 0); keyEnterIsPressed = 1'b1;
        step(2);
        chk("rst_aimPosX", int'(aimPosX), 0);
        chk("rst_drawLineEnable", int'(drawLineEnable), 0);
        chk("rst_shotValid", int'(shotValid), 0);
        chk("rst_shotSpeedX", int'(shotSpeedX), 0);

        // Enter held across reset release must not fire.
        reset = 1'b0;
        step(12);
        chk("held_enter_no_shot", n_shots, 0);
        chk("aim_after_reset", int'(drawLineEnable), 1);
        keyEnterIsPressed = 1'b0;
        ballPosX = 11'sd100; ballPosY = 11'sd200;
        step(2);

        keys(0, 1, 0, 0); frames(3); keys(0, 0, 0, 0);
        chk("right3_aimX", int'(aimPosX), 186);
        chk("right3_aimY", int'(aimPosY), 216);

        keys(0, 0, 1, 0); frames(70); keys(0, 0, 0, 0);
        chk("up_sat_aimY", int'(aimPosY), 88);

        keys(1, 1, 0, 0); frames(5); keys(0, 0, 0, 0);
        chk("lr_cancel_aimX", int'(aimPosX), 186);

        keys(1, 0, 0, 0); frames(3);
        keys(0, 0, 0, 1); frames(48); keys(0, 0, 0, 0);
        step(1);
        keyEnterIsPressed = 1'b1;
        step(1);
        for (int i = 0; i < 5 && shotValid !== 1'b1; i++) step(1);
        chk("shot_seen", int'(shotValid), 1);
        chk("shot_sx", int'(shotSpeedX), 256);
        chk("shot_sy", int'(shotSpeedY), -128);
        step(1);
        chk("shot_one_cycle", int'(shotValid), 0);
        chk("dle_drops", int'(drawLineEnable), 0);

        // Enter held well past the cooldown frames.
        frames(8);
        chk("cooldown_held", int'(drawLineEnable), 0);
        keyEnterIsPressed = 1'b0;
        step(4);
        chk("back_to_aim", int'(drawLineEnable), 1);

        // Drive the vector to zero, then press Enter: no shot.
        keys(1, 0, 0, 1); frames(16); keys(1, 0, 0, 0); frames(16); keys(0, 0, 0, 0);
        shots_before = n_shots;
        step(1);
        keyEnterIsPressed = 1'b1; step(6);
        chk("zero_vec_no_shot", n_shots, shots_before);
        chk("zero_vec_stays_aim", int'(drawLineEnable), 1);
        keyEnterIsPressed = 1'b0;

        keys(0, 1, 0, 0); frames(5); keys(0, 0, 0, 0);
        ballsStill = 1'b0; step(3);
        chk("not_still_no_line", int'(drawLineEnable), 0);
        ballsStill = 1'b1; step(3);
        chk("offset_kept_aimX", int'(aimPosX), 126);

        // Shot, then reset in the middle of cooldown.
        keyEnterIsPressed = 1'b1; step(1);
        for (int i = 0; i < 5 && shotValid !== 1'b1; i++) step(1);
        chk("shot2_sx", int'(shotSpeedX), 40);
        chk("shot2_sy", int'(shotSpeedY), 0);
        frames(2);
        reset = 1'b1; step(1);
        chk("mid_cd_reset_aimX", int'(aimPosX), 0);
        chk("mid_cd_reset_sx", int'(shotSpeedX), 0);
        reset = 1'b0; keyEnterIsPressed = 1'b0; step(3);
        chk("after_reset_aim", int'(drawLineEnable), 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            startOfFrame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                keyLeft  = ($urandom_range(0, 3) == 0);
                keyRight = ($urandom_range(0, 2) == 0);
                keyUp    = ($urandom_range(0, 2) == 0);
                keyDown  = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) keyEnterIsPressed = ~keyEnterIsPressed;
            if ($urandom_range(0, 15) == 0) ballsStill = ~ballsStill;
            if ($urandom_range(0, 31) == 0) begin
                ballPosX = 11'($urandom_range(0, 2047));
                ballPosY = 11'($urandom_range(0, 2047));
            end
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0; startOfFrame = 1'b0; keyEnterIsPressed = 1'b0;
        step(3);
        chk("shot_queue_drained", shotq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
